// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg
// Shared constants for the Wishbone GPIO bank: the register word indices,
// the width of the word address, and a helper that expands Wishbone byte
// selects into a 32-bit bit mask.
// No ports (package).

package gpio_bank_pkg;

    localparam int REG_ADDR_W = 4;

    localparam logic [REG_ADDR_W-1:0] REG_DATA_IN    = 4'd0;
    localparam logic [REG_ADDR_W-1:0] REG_DATA_OUT   = 4'd1;
    localparam logic [REG_ADDR_W-1:0] REG_DIR        = 4'd2;
    localparam logic [REG_ADDR_W-1:0] REG_OPEN_DRAIN = 4'd3;
    localparam logic [REG_ADDR_W-1:0] REG_IRQ_EN     = 4'd4;
    localparam logic [REG_ADDR_W-1:0] REG_IRQ_RISE   = 4'd5;
    localparam logic [REG_ADDR_W-1:0] REG_IRQ_FALL   = 4'd6;
    localparam logic [REG_ADDR_W-1:0] REG_IRQ_STATUS = 4'd7;
    localparam logic [REG_ADDR_W-1:0] REG_DEBOUNCE   = 4'd8;

    // Each byte-enable bit covers eight data bits.
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_bank_wb_debounce.sv
// gpio_debounce
// One GPIO input pin: a SYNC_STAGES-deep synchroniser, a saturating debounce
// counter and the debounced "stable" flop, plus one-cycle rise/fall pulses.
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   pad_i       raw pad value (asynchronous to clk_i)
//   debounce_i  number of extra cycles the synchronised value must persist
//   stable_o    debounced value
//   rise_o      1 for the cycle right after stable_o went 0->1
//   fall_o      1 for the cycle right after stable_o went 1->0

module gpio_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_WIDTH    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pad_i,
    input  logic [DB_WIDTH-1:0] debounce_i,
    output logic                stable_o,
    output logic                rise_o,
    output logic                fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stable_q, stable_d;
    logic [DB_WIDTH-1:0]    cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pad_i};
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync_s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= debounce_i) begin
            // ">=" rather than "==": if DEBOUNCE is lowered below the
            // running count the pin resolves next cycle instead of wrapping.
            stable_d = sync_s;
            cnt_d    = '0;
            rise_d   = sync_s;
            fall_d   = ~sync_s;
        end else begin
            cnt_d = cnt_q + DB_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/gpio_bank_wb.sv
// gpio_bank_wb
// Wishbone-slave GPIO bank: per-pin direction and open-drain mode, debounced
// inputs, and edge interrupts with write-1-to-clear status. Pad tristate
// buffers live in the chip top level; this block only supplies o/oe and
// consumes i.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_wb_adr/dat/sel/we/cyc/stb    Wishbone request (word address)
//   o_wb_rdt, o_wb_ack             Wishbone response
//   i_gpio                         pad input values
//   o_gpio, o_gpio_oe              pad output values / output enables
//   o_irq                          level interrupt

module gpio_bank_wb
    import gpio_bank_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               DB_WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] i_wb_adr,
    input  logic [31:0]           i_wb_dat,
    input  logic [3:0]            i_wb_sel,
    input  logic                  i_wb_we,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    output logic [31:0]           o_wb_rdt,
    output logic                  o_wb_ack,
    input  logic [WIDTH-1:0]      i_gpio,
    output logic [WIDTH-1:0]      o_gpio,
    output logic [WIDTH-1:0]      o_gpio_oe,
    output logic                  o_irq
);

    // Handshake: a request is cyc & stb while ack is low. It is captured on
    // the next edge, which raises ack for exactly one cycle and loads
    // rdt (read data for reads, 0 for writes). A captured write commits on
    // the following edge, the one on which the master samples ack. Because
    // ack masks the request, back-to-back requests are served every other
    // cycle. Reset clears ack and the captured write at once.

    logic [WIDTH-1:0]    data_out_q, data_out_d;
    logic [WIDTH-1:0]    dir_q, dir_d;
    logic [WIDTH-1:0]    od_q, od_d;
    logic [WIDTH-1:0]    irq_en_q, irq_en_d;
    logic [WIDTH-1:0]    irq_rise_q, irq_rise_d;
    logic [WIDTH-1:0]    irq_fall_q, irq_fall_d;
    logic [WIDTH-1:0]    irq_status_q, irq_status_d;
    logic [DB_WIDTH-1:0] debounce_q, debounce_d;

    logic                  ack_q, ack_d;
    logic [31:0]           rdt_q, rdt_d;
    logic                  irq_q, irq_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [REG_ADDR_W-1:0] wr_adr_q, wr_adr_d;
    logic [31:0]           wr_dat_q, wr_dat_d;
    logic [3:0]            wr_sel_q, wr_sel_d;

    logic                req;
    logic [31:0]         rd_data;
    logic [31:0]         wmask;
    logic [WIDTH-1:0]    wm_w, wd_w, w1c, edge_set;
    logic [DB_WIDTH-1:0] wm_db, wd_db;
    logic [WIDTH-1:0]    data_in, rise_w, fall_w;
    logic                unused_bits;

    assign req   = i_wb_cyc & i_wb_stb & ~ack_q;
    assign wmask = sel_to_mask(wr_sel_q);
    assign wm_w  = wmask[WIDTH-1:0];
    assign wd_w  = wr_dat_q[WIDTH-1:0];
    assign wm_db = wmask[DB_WIDTH-1:0];
    assign wd_db = wr_dat_q[DB_WIDTH-1:0];
    // Bits above WIDTH/DB_WIDTH have no register behind them.
    assign unused_bits = ^{wmask, wr_dat_q};

    function automatic logic [WIDTH-1:0] wmerge(input logic [WIDTH-1:0] old,
                                                input logic [WIDTH-1:0] dat,
                                                input logic [WIDTH-1:0] msk);
        return (old & ~msk) | (dat & msk);
    endfunction

    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        gpio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_WIDTH    (DB_WIDTH)
        ) u_db (
            .clk_i      (i_clk),
            .rst_ni     (i_rst_n),
            .pad_i      (i_gpio[g]),
            .debounce_i (debounce_q),
            .stable_o   (data_in[g]),
            .rise_o     (rise_w[g]),
            .fall_o     (fall_w[g])
        );
    end

    always_comb begin
        rd_data = '0;
        case (i_wb_adr)
            REG_DATA_IN:    rd_data = 32'(data_in);
            REG_DATA_OUT:   rd_data = 32'(data_out_q);
            REG_DIR:        rd_data = 32'(dir_q);
            REG_OPEN_DRAIN: rd_data = 32'(od_q);
            REG_IRQ_EN:     rd_data = 32'(irq_en_q);
            REG_IRQ_RISE:   rd_data = 32'(irq_rise_q);
            REG_IRQ_FALL:   rd_data = 32'(irq_fall_q);
            REG_IRQ_STATUS: rd_data = 32'(irq_status_q);
            REG_DEBOUNCE:   rd_data = 32'(debounce_q);
            default:        rd_data = '0;
        endcase
    end

    always_comb begin
        ack_d     = req;
        wr_pend_d = req & i_wb_we;
        rdt_d     = (req & ~i_wb_we) ? rd_data : 32'h0;
        wr_adr_d  = req ? i_wb_adr : wr_adr_q;
        wr_dat_d  = req ? i_wb_dat : wr_dat_q;
        wr_sel_d  = req ? i_wb_sel : wr_sel_q;

        data_out_d = data_out_q;
        dir_d      = dir_q;
        od_d       = od_q;
        irq_en_d   = irq_en_q;
        irq_rise_d = irq_rise_q;
        irq_fall_d = irq_fall_q;
        debounce_d = debounce_q;
        w1c        = '0;
        if (wr_pend_q) begin
            case (wr_adr_q)
                REG_DATA_OUT:   data_out_d = wmerge(data_out_q, wd_w, wm_w);
                REG_DIR:        dir_d      = wmerge(dir_q, wd_w, wm_w);
                REG_OPEN_DRAIN: od_d       = wmerge(od_q, wd_w, wm_w);
                REG_IRQ_EN:     irq_en_d   = wmerge(irq_en_q, wd_w, wm_w);
                REG_IRQ_RISE:   irq_rise_d = wmerge(irq_rise_q, wd_w, wm_w);
                REG_IRQ_FALL:   irq_fall_d = wmerge(irq_fall_q, wd_w, wm_w);
                REG_IRQ_STATUS: w1c        = wd_w & wm_w;
                REG_DEBOUNCE:   debounce_d = (debounce_q & ~wm_db) | (wd_db & wm_db);
                default:        w1c        = '0;
            endcase
        end

        // Set is applied after the clear so a new edge is never lost to a
        // concurrent W1C of the same bit.
        edge_set     = (rise_w & irq_rise_q) | (fall_w & irq_fall_q);
        irq_status_d = (irq_status_q & ~w1c) | edge_set;
        irq_d        = |(irq_status_q & irq_en_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_out_q   <= RESET_OUT;
            dir_q        <= RESET_DIR;
            od_q         <= '0;
            irq_en_q     <= '0;
            irq_rise_q   <= '0;
            irq_fall_q   <= '0;
            irq_status_q <= '0;
            debounce_q   <= '0;
            ack_q        <= 1'b0;
            rdt_q        <= '0;
            irq_q        <= 1'b0;
            wr_pend_q    <= 1'b0;
            wr_adr_q     <= '0;
            wr_dat_q     <= '0;
            wr_sel_q     <= '0;
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            od_q         <= od_d;
            irq_en_q     <= irq_en_d;
            irq_rise_q   <= irq_rise_d;
            irq_fall_q   <= irq_fall_d;
            irq_status_q <= irq_status_d;
            debounce_q   <= debounce_d;
            ack_q        <= ack_d;
            rdt_q        <= rdt_d;
            irq_q        <= irq_d;
            wr_pend_q    <= wr_pend_d;
            wr_adr_q     <= wr_adr_d;
            wr_dat_q     <= wr_dat_d;
            wr_sel_q     <= wr_sel_d;
        end
    end

    // Open-drain pins never drive high: they pull low only while DATA_OUT=0.
    // Input pins (DIR=0) never drive at all.
    assign o_gpio    = data_out_q & ~od_q;
    assign o_gpio_oe = dir_q & ~(od_q & data_out_q);

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_irq    = irq_q;

endmodule
